// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with a fast path for div-by-zero/overflow.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m_valid,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_next;
    logic [CNT_W-1:0]  counter;
    logic [2:0]        op;
    logic              neg_res;
    logic [XLEN-1:0]   opb;   // multiplicand or divisor
    logic [XLEN-1:0]   hi;    // product high half or partial remainder
    logic [XLEN-1:0]   lo;    // multiplier / product low half, or dividend / quotient

    // operand decode (IDLE acceptance)
    logic              sign_a, sign_b, use_abs_a, use_abs_b, res_sign;
    logic              is_div, div_zero, div_ovf, fast_path;
    logic [XLEN-1:0]   abs_a, abs_b, latch_a, latch_b, fast_res;

    // one iteration of each datapath
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

    always_comb begin
        sign_a    = rs1_val[XLEN-1];
        sign_b    = rs2_val[XLEN-1];
        abs_a     = sign_a ? -rs1_val : rs1_val;
        abs_b     = sign_b ? -rs2_val : rs2_val;
        use_abs_a = 1'b0;
        use_abs_b = 1'b0;
        res_sign  = 1'b0;
        case (func3)
            3'b001, 3'b100: begin
                use_abs_a = 1'b1;
                use_abs_b = 1'b1;
                res_sign  = sign_a ^ sign_b;
            end
            3'b010: begin
                use_abs_a = 1'b1;
                res_sign  = sign_a;
            end
            3'b110: begin
                use_abs_a = 1'b1;
                use_abs_b = 1'b1;
                res_sign  = sign_a;
            end
            default: ;
        endcase
        latch_a   = use_abs_a ? abs_a : rs1_val;
        latch_b   = use_abs_b ? abs_b : rs2_val;
        is_div    = func3[2];
        div_zero  = (rs2_val == '0);
        div_ovf   = !func3[0] && (rs1_val == MIN_INT) && (rs2_val == '1);
        fast_path = is_div && (div_zero || div_ovf);
        // func3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero)
            fast_res = func3[1] ? rs1_val : '1;
        else
            fast_res = func3[1] ? '0 : MIN_INT;
    end

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        mul_hi_n  = mul_sum[XLEN:1];
        mul_lo_n  = {mul_sum[0], lo[XLEN-1:1]};
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (!div_diff[XLEN]) begin
            div_hi_n = div_diff[XLEN-1:0];
            div_lo_n = {lo[XLEN-2:0], 1'b1};
        end else begin
            div_hi_n = div_shift[XLEN-1:0];
            div_lo_n = {lo[XLEN-2:0], 1'b0};
        end
        prod     = {mul_hi_n, mul_lo_n};
        prod_fix = neg_res ? -prod : prod;
        quot_fix = neg_res ? -div_lo_n : div_lo_n;
        rem_fix  = neg_res ? -div_hi_n : div_hi_n;
        // MUL never records a sign, so the corrected low word equals the raw one
        case (op)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quot_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        stall        = m_valid && (state != DONE) && !flush;
        result_valid = (state == DONE) && !flush;
        busy         = (state != IDLE);
        case (state)
            IDLE: if (m_valid) state_next = fast_path ? DONE : CALC;
            CALC: begin
                if (!m_valid)
                    state_next = IDLE;
                else if (counter == LAST)
                    state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            op      <= '0;
            neg_res <= 1'b0;
            opb     <= '0;
            hi      <= '0;
            lo      <= '0;
            result  <= '0;
        end else if (flush) begin
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        op      <= func3;
                        neg_res <= res_sign;
                        counter <= '0;
                        hi      <= '0;
                        opb     <= is_div ? latch_b : latch_a;
                        lo      <= is_div ? latch_a : latch_b;
                        if (fast_path)
                            result <= fast_res;
                    end
                end
                CALC: begin
                    if (!m_valid) begin
                        counter <= '0;
                    end else begin
                        counter <= (counter == LAST) ? '0 : counter + CNT_W'(1);
                        hi      <= op[2] ? div_hi_n : mul_hi_n;
                        lo      <= op[2] ? div_lo_n : mul_lo_n;
                        if (counter == LAST)
                            result <= final_res;
                    end
                end
                default: counter <= '0;
            endcase
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M instructions. It sits in the EX stage beside the ALU.
- When decode flags an M-type instruction, the block captures the operands and runs an iterative radix-2 multiply or divide, one bit per cycle.
- It holds the pipeline with a stall signal until the result is ready, then presents the result for one cycle.
- It also handles the RISC-V divide-by-zero and signed-overflow cases on a one-cycle fast path.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- m_valid  input  1  EX stage holds a valid M-type instruction (driven from m_type_inst).
- func3  input  3  M-op selector: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  input  XLEN  operand A (dividend / multiplicand).
- rs2_val  input  XLEN  operand B (divisor / multiplier).
- flush  input  1  EX-stage flush from branch or jump redirect.
- stall  output  1  holds IF/ID/EX pipeline registers.
- result_valid  output  1  result is valid this cycle.
- result  output  XLEN  M-op result for writeback.
- busy  output  1  state is not IDLE.

Behaviour:
- States: IDLE, CALC, DONE. After reset: state=IDLE, counter=0, result=0, result_valid=0, busy=0.
- stall is combinational: stall = m_valid && (state != DONE) && !flush. An M-op therefore stalls from its first EX cycle until the DONE cycle.

IDLE, when m_valid && !flush:
- Latch func3 and both operands.
- Signed ops (MULH, MULHSU for rs1 only, DIV, REM) latch absolute values and record the result sign:
  - MUL family: sign = signA XOR signB (MULHSU treats B as unsigned).
  - DIV: sign = signA XOR signB.
  - REM: sign = signA.
- MUL is signedness-agnostic; its low word is computed unsigned.
- Fast path (div/rem ops only), go directly to DONE:
  - Divisor == 0: quotient = all ones, remainder = rs1_val.
  - Signed DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Otherwise go to CALC with counter=0.

CALC, one iteration per cycle, XLEN iterations (counter 0..XLEN-1):
- Multiply: 2*XLEN-bit shift-add accumulator. Add the multiplicand when the current multiplier bit is 1, then shift.
- Divide: restoring division. Shift the remainder left, bring in the next dividend bit, subtract the divisor if the result is non-negative, and set the quotient bit.
- On counter == XLEN-1, go to DONE. Sign correction (two's complement negate when the recorded sign is 1) is applied in the DONE-entry register write.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits of the 2*XLEN product after sign correction.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.

DONE:
- result_valid=1 and result stable for exactly one cycle; stall=0, so the pipeline advances.
- Unconditional transition to IDLE. result holds its last value; result_valid=0.

Latency:
- Normal op: XLEN+1 stall cycles; result in cycle XLEN+2 after m_valid first rises (33 stall cycles and result in cycle 34 for XLEN=32).
- Fast path: 1 stall cycle.

Back-to-back and boundary cases:
- Back-to-back M-ops: the next instruction's m_valid is seen in IDLE the cycle after DONE; no bubble beyond the IDLE acceptance cycle.
- flush in any state: next state IDLE, counter cleared, no result_valid, stall=0 in that cycle.
- flush in DONE: result_valid is suppressed.
- rst mid-operation: same as flush, plus all outputs return to their reset values.
- m_valid dropping during CALC (not expected without flush) aborts to IDLE without result_valid.
- Operands and func3 are not re-sampled after IDLE.

Test Plan:
- MUL 7 * -3 (0x00000007, 0xFFFFFFFD) -> stall high 33 cycles, result 0xFFFFFFEB with result_valid one cycle.
- MULH 0x80000000 * 0x80000000 -> result 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -20 / 3 -> result 0xFFFFFFFA (-6). REM -20 / 3 -> 0xFFFFFFFE (-2). DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2. Each takes 33 stall cycles.
- DIVU 5 / 0 -> 1 stall cycle, result 0xFFFFFFFF. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Start DIV, assert flush at CALC iteration 10 -> IDLE next cycle, result_valid never asserted. A new MUL 3 * 4 issued next cycle -> 12.
- Two back-to-back MULs (2*3, then 4*5) -> two result_valid pulses with results 6 and 20. rst asserted mid-CALC -> busy=0, stall=0, result=0 the following cycle.
